// File: rtl/mac_t_rgmii.sv
// Transmit MAC framer: pops a descriptor, then streams preamble/SFD, payload,
// zero padding, FCS and the inter-frame gap as an SDR byte/nibble stream.
module mac_t_rgmii #(
  parameter int MIN_LEN   = 60,
  parameter int IFG_BYTES = 12,
  parameter int PRE_BYTES = 7
) (
  input  logic        tx_clk,
  input  logic        rst_sys,
  input  logic        speed,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [1:0]  tx_en_sdr,
  output logic [7:0]  tx_d_sdr,
  output logic        frame_sent,
  output logic        frame_dropped
);

  typedef enum logic [2:0] {IDLE, PTR, PRE, DATA, PAD, FCS, IFG, DROP} state_t;

  localparam logic [11:0] SFD_IDX   = 12'(PRE_BYTES);
  localparam logic [11:0] PAD_LAST  = 12'(MIN_LEN - 1);
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [11:0] IFG_LAST  = 12'(IFG_BYTES - 1);

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [11:0] len_reg;
  logic [11:0] len_last;
  logic        speed_reg;
  logic        phase_reg, phase_next;
  logic [7:0]  byte_reg;
  logic [31:0] crc_reg;
  logic [31:0] fcs;
  logic        slot_end;
  logic        slot_en;
  logic [7:0]  slot_byte;
  logic [3:0]  nib;
  logic [1:0]  en_next;
  logic [7:0]  d_next;
  logic        sent_next, dropped_next;
  logic        ptr_rd_c, data_rd_c;
  logic        crc_en;
  logic        unused_rsvd;

  assign unused_rsvd = ^ptr_fifo_dout[14:12];

  // Reflected 802.3 CRC-32, one byte per call
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // In MII mode a slot spans two clocks; phase_reg marks the high-nibble clock
  assign slot_end = speed_reg | phase_reg;
  assign len_last = len_reg - 12'd1;
  assign fcs      = ~crc_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    ptr_rd_c     = 1'b0;
    data_rd_c    = 1'b0;
    slot_en      = 1'b0;
    slot_byte    = 8'h00;
    sent_next    = 1'b0;
    dropped_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!ptr_fifo_empty) begin
          ptr_rd_c   = 1'b1;
          state_next = PTR;
        end
      end
      PTR: begin
        cnt_next = '0;
        if (ptr_fifo_dout[11:0] == 12'd0) begin
          dropped_next = 1'b1;
          state_next   = IDLE;
        end else if (ptr_fifo_dout[15]) begin
          state_next = DROP;
        end else begin
          state_next = PRE;
        end
      end
      PRE: begin
        slot_en   = 1'b1;
        slot_byte = (cnt_reg == SFD_IDX) ? 8'hD5 : 8'h55;
        if (slot_end) begin
          if (cnt_reg == SFD_IDX) begin
            data_rd_c  = 1'b1;
            cnt_next   = '0;
            state_next = DATA;
          end else begin
            cnt_next = cnt_reg + 12'd1;
          end
        end
      end
      DATA: begin
        slot_en   = 1'b1;
        slot_byte = phase_reg ? byte_reg : data_fifo_dout;
        if (slot_end) begin
          if (cnt_reg == len_last) begin
            // the byte count keeps running through PAD so padding ends at MIN_LEN
            if (len_reg < MIN_LEN_W) begin
              cnt_next   = cnt_reg + 12'd1;
              state_next = PAD;
            end else begin
              cnt_next   = '0;
              state_next = FCS;
            end
          end else begin
            data_rd_c = 1'b1;
            cnt_next  = cnt_reg + 12'd1;
          end
        end
      end
      PAD: begin
        slot_en = 1'b1;
        if (slot_end) begin
          if (cnt_reg == PAD_LAST) begin
            cnt_next   = '0;
            state_next = FCS;
          end else begin
            cnt_next = cnt_reg + 12'd1;
          end
        end
      end
      FCS: begin
        slot_en = 1'b1;
        case (cnt_reg[1:0])
          2'd0:    slot_byte = fcs[7:0];
          2'd1:    slot_byte = fcs[15:8];
          2'd2:    slot_byte = fcs[23:16];
          default: slot_byte = fcs[31:24];
        endcase
        if (slot_end) begin
          if (cnt_reg[1:0] == 2'd3) begin
            cnt_next   = '0;
            state_next = IFG;
          end else begin
            cnt_next = cnt_reg + 12'd1;
          end
        end
      end
      IFG: begin
        sent_next = (cnt_reg == 12'd0) && !phase_reg;
        if (slot_end) begin
          if (cnt_reg == IFG_LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 12'd1;
          end
        end
      end
      DROP: begin
        data_rd_c = 1'b1;
        if (cnt_reg == len_last) begin
          dropped_next = 1'b1;
          cnt_next     = '0;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    phase_next = 1'b0;
    if (state_reg inside {PRE, DATA, PAD, FCS, IFG})
      phase_next = !speed_reg && !phase_reg;
    nib     = phase_reg ? slot_byte[7:4] : slot_byte[3:0];
    en_next = {2{slot_en}};
    d_next  = 8'h00;
    if (slot_en)
      d_next = speed_reg ? slot_byte : {nib, nib};
  end

  assign crc_en       = (state_reg == DATA || state_reg == PAD) && !phase_reg;
  assign ptr_fifo_rd  = ptr_rd_c & ~rst_sys;
  assign data_fifo_rd = data_rd_c & ~rst_sys;

  always_ff @(posedge tx_clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      speed_reg     <= 1'b0;
      phase_reg     <= 1'b0;
      byte_reg      <= '0;
      crc_reg       <= '1;
      tx_en_sdr     <= '0;
      tx_d_sdr      <= '0;
      frame_sent    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
      tx_en_sdr     <= en_next;
      tx_d_sdr      <= d_next;
      frame_sent    <= sent_next;
      frame_dropped <= dropped_next;
      if (state_reg == IDLE)
        speed_reg <= speed;
      if (state_reg == PTR) begin
        len_reg <= ptr_fifo_dout[11:0];
        crc_reg <= '1;
      end
      if (state_reg == DATA && !phase_reg)
        byte_reg <= data_fifo_dout;
      if (crc_en)
        crc_reg <= crc_upd(crc_reg, slot_byte);
    end
  end

endmodule
